// File: rtl/guess_scorer.sv
// Bulls-and-cows scorer: registers a BCD secret and guess, validates the guess,
// then walks all 16 digit pairs to count exact (bulls) and misplaced (cows) matches.
module guess_scorer #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_DIGITS*DIGIT_W-1:0]   secret,
  input  logic [N_DIGITS*DIGIT_W-1:0]   guess,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    bulls,
  output logic [2:0]                    cows,
  output logic                          win,
  output logic                          invalid
);

  localparam int CODE_W = N_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                    state;
  logic        [3:0]         k;
  logic        [2:0]         bull_acc;
  logic        [2:0]         cow_acc;
  logic        [CODE_W-1:0]  secret_p0;
  logic        [CODE_W-1:0]  guess_p0;

  logic        [DIGIT_W-1:0] guess_digit;
  logic        [DIGIT_W-1:0] secret_digit;
  logic                      is_bull;
  logic                      is_cow;
  logic        [2:0]         bull_next;
  logic        [2:0]         cow_next;
  logic                      guess_ok;

  function automatic logic [DIGIT_W-1:0] digit_at(input logic [CODE_W-1:0] code,
                                                  input logic [1:0]        idx);
    return code[int'(idx)*DIGIT_W +: DIGIT_W];
  endfunction

  // A guess is usable only if every digit is BCD and no digit repeats.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (code[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) ok = 1'b0;
      for (int j = i + 1; j < N_DIGITS; j++) begin
        if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  always_comb begin
    guess_digit  = digit_at(guess_p0, k[3:2]);
    secret_digit = digit_at(secret_p0, k[1:0]);
    is_bull      = 1'b0;
    is_cow       = 1'b0;
    if (guess_digit == secret_digit) begin
      if (k[3:2] == k[1:0]) is_bull = 1'b1;
      else                  is_cow  = 1'b1;
    end
    bull_next = bull_acc + (is_bull ? 3'd1 : 3'd0);
    cow_next  = cow_acc  + (is_cow  ? 3'd1 : 3'd0);
    guess_ok  = code_valid(guess_p0);
  end

  // Operand capture: only in IDLE, so inputs are never re-sampled while busy.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      secret_p0 <= secret;
      guess_p0  <= guess;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= 4'd0;
      bull_acc <= 3'd0;
      cow_acc  <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bulls    <= 3'd0;
      cows     <= 3'd0;
      win      <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k        <= 4'd0;
            bull_acc <= 3'd0;
            cow_acc  <= 3'd0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (!guess_ok) begin
            bulls   <= 3'd0;
            cows    <= 3'd0;
            win     <= 1'b0;
            invalid <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          bull_acc <= bull_next;
          cow_acc  <= cow_next;
          // Last pair publishes directly, including its own match.
          if (k == 4'd15) begin
            bulls   <= bull_next;
            cows    <= cow_next;
            win     <= (bull_next == 3'd4);
            invalid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_scorer.sv
// Directed-vector bench for guess_scorer: latency, scoring, invalid guesses,
// start held high, mid-operation reset and output hold between results.
module tb_guess_scorer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] secret;
  logic [15:0] guess;
  logic        busy;
  logic        done;
  logic [2:0]  bulls;
  logic [2:0]  cows;
  logic        win;
  logic        invalid;

  int vectors;
  int miscompares;

  guess_scorer #(.N_DIGITS(4), .DIGIT_W(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .secret  (secret),
    .guess   (guess),
    .busy    (busy),
    .done    (done),
    .bulls   (bulls),
    .cows    (cows),
    .win     (win),
    .invalid (invalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] pack(input logic [2:0] b, input logic [2:0] c,
                                      input logic w, input logic i);
    return {b, c, w, i};
  endfunction

  // One scoring run with a 1-cycle start; prior is the result expected to hold until done.
  task automatic score(input string tag, input logic [15:0] s, input logic [15:0] g,
                       input int exp_cyc, input logic [7:0] expect_res, input logic [7:0] prior);
    int cyc;
    secret = s;
    guess  = g;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (done) break;
      check($sformatf("%s busy c%0d", tag, cyc), 32'(busy), 32'd1);
      check($sformatf("%s hold c%0d", tag, cyc), 32'(pack(bulls, cows, win, invalid)), 32'(prior));
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    check({tag, " result"}, 32'(pack(bulls, cows, win, invalid)), 32'(expect_res));
    @(posedge clock); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " result held"}, 32'(pack(bulls, cows, win, invalid)), 32'(expect_res));
  endtask

  initial begin
    int pulses;
    int dcyc;
    logic [7:0] res;

    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    start  = 1'b0;
    secret = 16'h0000;
    guess  = 16'h0000;

    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset outputs", 32'(pack(bulls, cows, win, invalid)), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    score("exact", 16'h1234, 16'h1234, 18, pack(3'd4, 3'd0, 1'b1, 1'b0), 8'h00);
    score("reverse", 16'h1234, 16'h4321, 18, pack(3'd0, 3'd4, 1'b0, 1'b0), pack(3'd4, 3'd0, 1'b1, 1'b0));
    score("swap", 16'h1234, 16'h1243, 18, pack(3'd2, 3'd2, 1'b0, 1'b0), pack(3'd0, 3'd4, 1'b0, 1'b0));
    score("repeat", 16'h1234, 16'h1123, 2, pack(3'd0, 3'd0, 1'b0, 1'b1), pack(3'd2, 3'd2, 1'b0, 1'b0));
    score("nonbcd", 16'h1234, 16'h12A4, 2, pack(3'd0, 3'd0, 1'b0, 1'b1), pack(3'd0, 3'd0, 1'b0, 1'b1));

    // start held high through the whole run; guess changes mid-COMPARE
    secret = 16'h1234;
    guess  = 16'h1243;
    start  = 1'b1;
    @(posedge clock); #1;
    pulses = 0;
    dcyc   = 0;
    res    = 8'h00;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) guess = 16'h1234;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          dcyc = c;
          res  = pack(bulls, cows, win, invalid);
        end
      end
      if (c == 19) start = 1'b0;
      @(posedge clock); #1;
    end
    check("held start pulses", 32'(pulses), 32'd1);
    check("held start latency", 32'(dcyc), 32'd18);
    check("held start result", 32'(res), 32'(pack(3'd2, 3'd2, 1'b0, 1'b0)));

    // reset during COMPARE at k = 9 (cycle 11 after acceptance)
    secret = 16'h1234;
    guess  = 16'h1234;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("pre-abort busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort outputs", 32'(pack(bulls, cows, win, invalid)), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (c == 2) reset = 1'b1;
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);

    score("after reset", 16'h5678, 16'h5678, 18, pack(3'd4, 3'd0, 1'b1, 1'b0), 8'h00);
    score("no match", 16'h9081, 16'h7632, 18, pack(3'd0, 3'd0, 1'b0, 1'b0), pack(3'd4, 3'd0, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Clock port is named clock and reset port is named reset.
REQ-002 Parameter: N_DIGITS, 4, number of BCD digits per code (only 4 supported).
REQ-003 Parameter: DIGIT_W, 4, bits per digit.
REQ-004 Port: clock  in  1  system clock, rising-edge.
REQ-005 Port: reset  in  1  asynchronous reset, active-low.
REQ-006 Port: start  in  1  request to score; sampled only in IDLE.
REQ-007 Port: secret  in  16  four BCD digits; digit 3 = [15:12], digit 0 = [3:0].
REQ-008 Port: guess  in  16  four BCD digits, same packing as secret.
REQ-009 Port: busy  out  1  high in CHECK and COMPARE.
REQ-010 Port: done  out  1  one-cycle pulse when a result is published.
REQ-011 Port: bulls  out  3  count of same digit, same position (0..4).
REQ-012 Port: cows  out  3  count of same digit, different position (0..4).
REQ-013 Port: win  out  1  high when bulls == 4 and the guess is valid.
REQ-014 Port: invalid  out  1  high when the last guess had a digit > 9 or a repeated digit.

Function
REQ-015 The FSM SHALL have four states: IDLE, CHECK, COMPARE and DONE.
REQ-016 In IDLE with start = 1, the block SHALL register secret and guess, clear the internal accumulators and the 4-bit pair index, and go to CHECK.
REQ-017 The block SHALL ignore start in all states other than IDLE and SHALL NOT re-sample the inputs while busy.
REQ-018 CHECK SHALL last 1 cycle and evaluate the registered guess. If any digit > 9, or any two digits are equal, the block SHALL go to DONE with the invalid result; otherwise it SHALL go to COMPARE.
REQ-019 COMPARE SHALL last exactly 16 cycles.
- Pair index k = 0..15, with guess digit i = k[3:2] and secret digit j = k[1:0].
- On a match with i == j, the bulls accumulator increments.
- On a match with i != j, the cows accumulator increments.
- After k = 15 the block SHALL go to DONE; k SHALL NOT wrap into a 17th compare.
- Accumulators are 3 bits wide and SHALL NOT overflow: at most 4 matches are possible with a valid guess.
REQ-020 On entering DONE, the block SHALL load the registered outputs:
- valid guess: bulls and cows from the accumulators, win = (bulls == 4), invalid = 0;
- invalid guess: bulls = 0, cows = 0, win = 0, invalid = 1.
REQ-021 DONE SHALL last 1 cycle with done = 1 and busy = 0, then return to IDLE. A start asserted during DONE is ignored.
REQ-022 Latency, counted from the edge that samples start: done SHALL be high during the 18th cycle for a valid guess and the 2nd cycle for an invalid guess.
REQ-023 bulls, cows, win and invalid SHALL hold their value between done pulses and change only on entry to DONE.
REQ-024 Secret validity SHALL NOT be checked. Upstream guarantees distinct BCD digits; with a malformed secret the counts are defined only by REQ-019.
REQ-025 All outputs SHALL be registered; no combinational path from start, secret or guess to any output.

Reset
REQ-026 While reset = 0, the state SHALL be IDLE and busy, done, bulls, cows, win, invalid, the accumulators and k SHALL all be 0.
REQ-027 Reset asserted mid-operation SHALL abort scoring immediately, with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-028 secret 0x1234, guess 0x1234, 1-cycle start -> done in cycle 18, bulls = 4, cows = 0, win = 1, invalid = 0.
REQ-029 secret 0x1234, guess 0x4321 -> bulls = 0, cows = 4, win = 0. Then guess 0x1243 -> bulls = 2, cows = 2.
REQ-030 secret 0x1234, guess 0x1123 and then guess 0x12A4 -> each gives done in cycle 2, invalid = 1, bulls = cows = win = 0.
REQ-031 start held high for 20 cycles, guess changed mid-COMPARE -> exactly one done, and the result reflects the guess sampled at acceptance.
REQ-032 reset pulled low at COMPARE k = 9 -> all outputs 0 at once, no done pulse; the next start with 0x5678/0x5678 gives win = 1.
REQ-033 secret 0x9081, guess 0x7632 -> bulls = 0, cows = 0, win = 0, invalid = 0; prior outputs hold until this done.
